// File: rtl/glcd_bus_ctrl.sv
// glcd_bus_ctrl: write-only bus sequencer for a 128x64 dual-controller graphic LCD.
// Define GLCD_STARTLINE_EN to add the scroll_line input and display start-line commands.
module glcd_bus_ctrl #(
    parameter int PWRUP_CYC  = 1024,
    parameter int SETUP_CYC  = 8,
    parameter int E_HIGH_CYC = 32,
    parameter int E_LOW_CYC  = 32
) (
    input  logic       clk,
    input  logic       rst,
`ifdef GLCD_STARTLINE_EN
    input  logic [5:0] scroll_line,
`endif
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_page,
    input  logic [6:0] wr_col,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic       lcd_rst,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       cs1,
    output logic       cs2,
    output logic [7:0] lcd_data
);
    localparam int T_CYC   = SETUP_CYC + E_HIGH_CYC + E_LOW_CYC;
    localparam int CNT_MAX = (PWRUP_CYC > T_CYC) ? PWRUP_CYC : T_CYC;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] CNT_PWR_LAST = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] CNT_BUS_LAST = CW'(T_CYC - 1);
    localparam logic [CW-1:0] E_RISE       = CW'(SETUP_CYC);
    localparam logic [CW-1:0] E_FALL       = CW'(SETUP_CYC + E_HIGH_CYC);

    typedef enum logic [2:0] {
        S_PWRUP, S_DISP_ON, S_START, S_IDLE, S_SET_PAGE, S_SET_COL, S_DATA
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            bus_done, accept, line_change;
    logic            req_half;
    logic [2:0]      req_page;
    logic [5:0]      req_y;
    logic [7:0]      req_data;
    logic [1:0]      addr_valid;
    logic [2:0]      trk_page [2];
    logic [5:0]      trk_col  [2];
    logic            in_half, need_page_in, need_col_in, need_col_req;
    logic            half_n;
    logic [2:0]      page_n;
    logic [5:0]      y_n;
    logic [7:0]      wdata_n;
    logic            e_n, rs_n, cs1_n, cs2_n;
    logic [7:0]      data_n;

`ifdef GLCD_STARTLINE_EN
    logic [5:0] sent_line, line_n;
    assign line_change = (scroll_line != sent_line);
    assign line_n      = (state == S_IDLE && line_change) ? scroll_line : sent_line;
`else
    assign line_change = 1'b0;
`endif

    // Handshake: a request transfers on any cycle where wr_valid && wr_ready; wr_ready is
    // high only in IDLE after init and with no start-line update pending, and the
    // request fields are captured on that same edge. Unaccepted requests are dropped.
    assign wr_ready = (state == S_IDLE) && init_done && !line_change;
    assign accept   = wr_valid && wr_ready;
    assign lcd_rw   = 1'b0;
    assign bus_done = (cnt == CNT_BUS_LAST);

    assign in_half      = wr_col[6];
    assign need_page_in = !addr_valid[in_half] || (trk_page[in_half] != wr_page);
    assign need_col_in  = !addr_valid[in_half] || (trk_col[in_half] != wr_col[5:0]);
    assign need_col_req = !addr_valid[req_half] || (trk_col[req_half] != req_y);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        case (state)
            S_PWRUP: if (cnt == CNT_PWR_LAST) begin
                state_n = S_DISP_ON;
                cnt_n   = '0;
            end
            S_DISP_ON: if (bus_done) begin
`ifdef GLCD_STARTLINE_EN
                state_n = S_START;
`else
                state_n = S_IDLE;
`endif
                cnt_n   = '0;
            end
            S_START: if (bus_done) begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            S_IDLE: begin
                cnt_n = '0;
                if (line_change && init_done) begin
                    state_n = S_START;
                end else if (accept) begin
                    state_n = need_page_in ? S_SET_PAGE : (need_col_in ? S_SET_COL : S_DATA);
                end
            end
            S_SET_PAGE: if (bus_done) begin
                state_n = need_col_req ? S_SET_COL : S_DATA;
                cnt_n   = '0;
            end
            S_SET_COL: if (bus_done) begin
                state_n = S_DATA;
                cnt_n   = '0;
            end
            S_DATA: if (bus_done) begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_PWRUP;
                cnt_n   = '0;
            end
        endcase
    end

    // Bus pins are registered from the next state so they change cleanly on clock edges.
    assign half_n  = accept ? wr_col[6]   : req_half;
    assign page_n  = accept ? wr_page     : req_page;
    assign y_n     = accept ? wr_col[5:0] : req_y;
    assign wdata_n = accept ? wr_data     : req_data;

    always_comb begin
        cs1_n  = 1'b0;
        cs2_n  = 1'b0;
        rs_n   = 1'b0;
        data_n = 8'h00;
        e_n    = (state_n inside {S_DISP_ON, S_START, S_SET_PAGE, S_SET_COL, S_DATA})
                 && (cnt_n >= E_RISE) && (cnt_n < E_FALL);
        case (state_n)
            S_DISP_ON: begin
                cs1_n  = 1'b1;
                cs2_n  = 1'b1;
                data_n = 8'h3F;
            end
`ifdef GLCD_STARTLINE_EN
            S_START: begin
                cs1_n  = 1'b1;
                cs2_n  = 1'b1;
                data_n = {2'b11, line_n};
            end
`endif
            S_SET_PAGE: begin
                cs1_n  = !half_n;
                cs2_n  = half_n;
                data_n = {5'b10111, page_n};
            end
            S_SET_COL: begin
                cs1_n  = !half_n;
                cs2_n  = half_n;
                data_n = {2'b01, y_n};
            end
            S_DATA: begin
                cs1_n  = !half_n;
                cs2_n  = half_n;
                rs_n   = 1'b1;
                data_n = wdata_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_PWRUP;
            cnt         <= '0;
            req_half    <= 1'b0;
            req_page    <= '0;
            req_y       <= '0;
            req_data    <= '0;
            addr_valid  <= '0;
            trk_page[0] <= '0;
            trk_page[1] <= '0;
            trk_col[0]  <= '0;
            trk_col[1]  <= '0;
            init_done   <= 1'b0;
            lcd_rst     <= 1'b0;
            lcd_e       <= 1'b0;
            lcd_rs      <= 1'b0;
            cs1         <= 1'b0;
            cs2         <= 1'b0;
            lcd_data    <= '0;
`ifdef GLCD_STARTLINE_EN
            sent_line   <= '0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            lcd_e    <= e_n;
            lcd_rs   <= rs_n;
            cs1      <= cs1_n;
            cs2      <= cs2_n;
            lcd_data <= data_n;
            if (accept) begin
                req_half <= wr_col[6];
                req_page <= wr_page;
                req_y    <= wr_col[5:0];
                req_data <= wr_data;
            end
            if (state == S_PWRUP && state_n == S_DISP_ON)
                lcd_rst <= 1'b1;
            if (state == S_DISP_ON && bus_done)
                init_done <= 1'b1;
            // Panel column counter auto-increments and wraps within its 64-column half.
            if (state == S_DATA && bus_done) begin
                trk_page[req_half]   <= req_page;
                trk_col[req_half]    <= req_y + 6'd1;
                addr_valid[req_half] <= 1'b1;
            end
`ifdef GLCD_STARTLINE_EN
            if (state == S_IDLE && line_change && init_done)
                sent_line <= scroll_line;
`endif
        end
    end
endmodule

// File: tb/tb_glcd_bus_ctrl.sv
// Directed bench for glcd_bus_ctrl: power-up, address tracking, wrap, mid-cycle reset.
// Exercises the start-line path too when GLCD_STARTLINE_EN is defined.
module tb_glcd_bus_ctrl;
    localparam int T = 72;
`ifdef GLCD_STARTLINE_EN
    localparam int INIT_LAT = 2 * T;
`else
    localparam int INIT_LAT = T;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_page = '0;
    logic [6:0] wr_col = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ready, init_done, lcd_rst, lcd_e, lcd_rs, lcd_rw, cs1, cs2;
    logic [7:0] lcd_data;
`ifdef GLCD_STARTLINE_EN
    logic [5:0] scroll_line = '0;
`endif

    always #5 clk = ~clk;

    glcd_bus_ctrl dut (
        .clk(clk),
        .rst(rst),
`ifdef GLCD_STARTLINE_EN
        .scroll_line(scroll_line),
`endif
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_page(wr_page),
        .wr_col(wr_col),
        .wr_data(wr_data),
        .init_done(init_done),
        .lcd_rst(lcd_rst),
        .lcd_e(lcd_e),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .cs1(cs1),
        .cs2(cs2),
        .lcd_data(lcd_data)
    );

    // Scoreboard: expected E pulses as {cs1, cs2, rs, data}
    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic exp_pulse(input logic c1, input logic c2, input logic rs, input logic [7:0] d);
        exp_q.push_back({c1, c2, rs, d});
    endtask

    // Bus monitor: every rising E must match the next expected pulse, bus stays put
    // while E is high, and E-high lasts exactly 32 cycles.
    logic        e_prev = 1'b0;
    int          hcnt = 0;
    logic [10:0] cur = '0;
    always @(negedge clk) begin
        if (rst) begin
            e_prev = 1'b0;
            hcnt   = 0;
        end else begin
            if (lcd_e && !e_prev) begin
                cur = {cs1, cs2, lcd_rs, lcd_data};
                check("pulse_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("pulse", cur, exp_q.pop_front());
                check("rw_low", lcd_rw, 0);
                hcnt = 1;
            end else if (lcd_e) begin
                hcnt++;
                check("bus_stable", {cs1, cs2, lcd_rs, lcd_data}, cur);
            end else if (e_prev) begin
                check("e_high_width", hcnt, 32);
            end
            e_prev = lcd_e;
        end
    end

    task automatic power_up(input string tag);
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_rst_outputs"},
              {lcd_rst, lcd_e, lcd_rs, lcd_rw, cs1, cs2, lcd_data, wr_ready, init_done}, 0);
        exp_pulse(1'b1, 1'b1, 1'b0, 8'h3F);
`ifdef GLCD_STARTLINE_EN
        exp_pulse(1'b1, 1'b1, 1'b0, 8'hC0);
`endif
        rst = 1'b0;
        n = 0;
        while (!lcd_rst && n < 5000) begin @(negedge clk); n++; end
        check({tag, "_lcd_rst_low_cycles"}, n, 1024);
        check({tag, "_init_done_early"}, init_done, 0);
        n = 0;
        while (!wr_ready && n < 1000) begin @(negedge clk); n++; end
        check({tag, "_init_latency"}, n, INIT_LAT);
        check({tag, "_init_done"}, init_done, 1);
        check({tag, "_init_pulses_left"}, exp_q.size(), 0);
    endtask

    task automatic do_write(input logic [2:0] p, input logic [6:0] c, input logic [7:0] d,
                            input int lat, input logic hold, input string tag);
        int n;
        n = 0;
        while (!wr_ready && n < 1000) begin @(negedge clk); n++; end
        check({tag, "_ready"}, wr_ready, 1);
        wr_valid = 1'b1;
        wr_page  = p;
        wr_col   = c;
        wr_data  = d;
        @(negedge clk);
        // Optionally keep a different request on the bus while busy; it must be ignored.
        wr_valid = hold;
        wr_page  = ~p;
        wr_col   = ~c;
        wr_data  = ~d;
        n = 0;
        while (!wr_ready && n < 1000) begin @(negedge clk); n++; end
        wr_valid = 1'b0;
        check({tag, "_latency"}, n, lat);
        check({tag, "_pulses_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        power_up("pwr1");

        exp_pulse(1, 0, 0, 8'hBA); exp_pulse(1, 0, 0, 8'h45); exp_pulse(1, 0, 1, 8'hA5);
        do_write(3'd2, 7'd5, 8'hA5, 3 * T, 1'b0, "w_p2c5");

        exp_pulse(1, 0, 1, 8'h3C);
        do_write(3'd2, 7'd6, 8'h3C, T, 1'b1, "w_p2c6_hold");

        exp_pulse(0, 1, 0, 8'hBA); exp_pulse(0, 1, 0, 8'h46); exp_pulse(0, 1, 1, 8'h11);
        do_write(3'd2, 7'd70, 8'h11, 3 * T, 1'b0, "w_p2c70");

        exp_pulse(1, 0, 0, 8'hB8); exp_pulse(1, 0, 0, 8'h7E); exp_pulse(1, 0, 1, 8'h81);
        do_write(3'd0, 7'd62, 8'h81, 3 * T, 1'b0, "w_p0c62");

        exp_pulse(1, 0, 1, 8'h82);
        do_write(3'd0, 7'd63, 8'h82, T, 1'b0, "w_p0c63");

        exp_pulse(1, 0, 1, 8'h83);
        do_write(3'd0, 7'd0, 8'h83, T, 1'b0, "w_p0c0_wrap");

        exp_pulse(1, 0, 0, 8'hB9); exp_pulse(1, 0, 1, 8'h55);
        do_write(3'd1, 7'd1, 8'h55, 2 * T, 1'b0, "w_p1c1_page_only");

        exp_pulse(0, 1, 1, 8'h66);
        do_write(3'd2, 7'd71, 8'h66, T, 1'b0, "w_p2c71_right_kept");

        exp_pulse(0, 1, 0, 8'hBF); exp_pulse(0, 1, 0, 8'h7F); exp_pulse(0, 1, 1, 8'hF0);
        do_write(3'd7, 7'd127, 8'hF0, 3 * T, 1'b0, "w_p7c127");

        exp_pulse(0, 1, 1, 8'h0F);
        do_write(3'd7, 7'd64, 8'h0F, T, 1'b0, "w_p7c64_wrap");

        // Reset during E-high of the data cycle
        exp_pulse(1, 0, 0, 8'hBB); exp_pulse(1, 0, 0, 8'h4A); exp_pulse(1, 0, 1, 8'h77);
        n = 0;
        while (!wr_ready && n < 1000) begin @(negedge clk); n++; end
        wr_valid = 1'b1; wr_page = 3'd3; wr_col = 7'd10; wr_data = 8'h77;
        @(negedge clk);
        wr_valid = 1'b0;
        n = 0;
        while (!(lcd_e && lcd_rs) && n < 1000) begin @(negedge clk); n++; end
        check("rst_reached_data_e", {lcd_e, lcd_rs}, 2'b11);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_e", lcd_e, 0);
        check("rst_async_lcd_rst", lcd_rst, 0);
        check("rst_async_cs", {cs1, cs2}, 0);
        check("rst_async_rs_data", {lcd_rs, lcd_data}, 0);
        check("rst_async_ready_init", {wr_ready, init_done}, 0);
        check("rst_pulses_left", exp_q.size(), 0);

        power_up("pwr2");
        exp_pulse(1, 0, 0, 8'hBA); exp_pulse(1, 0, 0, 8'h46); exp_pulse(1, 0, 1, 8'h3C);
        do_write(3'd2, 7'd6, 8'h3C, 3 * T, 1'b0, "w_after_rst");

`ifdef GLCD_STARTLINE_EN
        @(negedge clk);
        scroll_line = 6'd9;
        exp_pulse(1, 1, 0, 8'hC9); exp_pulse(1, 0, 1, 8'h5A);
        do_write(3'd2, 7'd7, 8'h5A, T, 1'b0, "w_scroll9");
        exp_pulse(1, 0, 1, 8'h5B);
        do_write(3'd2, 7'd8, 8'h5B, T, 1'b0, "w_scroll_same");
`endif

        repeat (5) @(negedge clk);
        check("final_pulses_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
